// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port control slice.
//   RF_AW / RF_DW / RF_NREQ / RF_LOCK_TMO : default geometry and lock timeout
//   arb_state_t                           : write-arbiter FSM states
//   clog2_min1()                          : index width helper, never below 1
package rf_ctrl_pkg;

  localparam int unsigned RF_AW       = 4;
  localparam int unsigned RF_DW       = 32;
  localparam int unsigned RF_NREQ     = 3;
  localparam int unsigned RF_LOCK_TMO = 8;

  typedef enum logic {
    IDLE,
    LOCK
  } arb_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational rotating pick: first set bit of valid at or after ptr,
// wrapping modulo NREQ. Fixed priority is obtained by tying ptr to 0.
//   valid : request vector
//   ptr   : index where the scan starts
//   gnt   : one-hot grant (all-zero when nothing is valid)
//   idx   : index of the granted bit
//   any   : at least one request is valid
module rf_rr_pick #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!any && valid[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port among NREQ writeback
// requesters using valid/ready handshakes, with locked bursts that let one
// requester own the port for consecutive writes. The rf_* outputs are
// registered: a write accepted at edge t is presented during t..t+1.
//
// Build option: RF_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) in IDLE and removes the round-robin pointer; default is round-robin.
//
// Ports:
//   Clk       : clock, all state on rising edge
//   Clr       : synchronous active-high reset
//   req_valid : per-requester write pending
//   req_ready : per-requester accept (combinational, at most one hot)
//   req_addr  : packed destination registers, slice i = [i*AW +: AW]
//   req_data  : packed write data, slice i = [i*DW +: DW]
//   req_lock  : keep the port after this transfer
//   rf_ld     : register file load enable
//   rf_addr   : register file destination select
//   rf_data   : register file write data
//   grant_id  : index of the last accepted requester
//   busy      : high while a requester holds the lock
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter  int unsigned NREQ     = RF_NREQ,
  parameter  int unsigned DW       = RF_DW,
  parameter  int unsigned AW       = RF_AW,
  parameter  int unsigned LOCK_TMO = RF_LOCK_TMO,
  localparam int unsigned IW       = clog2_min1(NREQ),
  localparam int unsigned TW       = clog2_min1(LOCK_TMO)
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]  req_lock,
  output logic             rf_ld,
  output logic [AW-1:0]    rf_addr,
  output logic [DW-1:0]    rf_data,
  output logic [IW-1:0]    grant_id,
  output logic             busy
);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   ptr_nxt, pick_ptr;
  logic [TW-1:0]   tmo, tmo_nxt;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            xfer, xlock;
  logic [IW-1:0]   xidx;
  logic [AW-1:0]   addr_sel;
  logic [DW-1:0]   data_sel;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] v);
    return (v == IW'(NREQ - 1)) ? '0 : v + IW'(1);
  endfunction

`ifdef RF_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IW-1:0] ptr;

  always_ff @(posedge Clk) begin
    if (Clr) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  assign pick_ptr = ptr;
`endif

  rf_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Ready is gated by Clr so a transfer coincident with reset is never seen.
  always_comb begin
    req_ready = '0;
    if (!Clr) begin
      if (state == IDLE) begin
        if (pick_any) req_ready = pick_gnt;
      end else if (req_valid[owner]) begin
        req_ready[owner] = 1'b1;
      end
    end
  end

  assign xfer  = |req_ready;
  assign xidx  = (state == LOCK) ? owner : pick_idx;
  assign xlock = req_lock[xidx];
  assign busy  = (state == LOCK);

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (xidx == IW'(i)) begin
        addr_sel = req_addr[i*AW +: AW];
        data_sel = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    tmo_nxt   = tmo;
    ptr_nxt   = pick_ptr;
    case (state)
      IDLE: begin
        if (xfer) begin
          ptr_nxt = inc_mod(pick_idx);
          if (xlock) begin
            state_nxt = LOCK;
            owner_nxt = pick_idx;
            tmo_nxt   = '0;
          end
        end
      end
      LOCK: begin
        if (xfer) begin
          if (xlock) begin
            tmo_nxt = '0;
          end else begin
            state_nxt = IDLE;
            ptr_nxt   = inc_mod(owner);
          end
        end else if (tmo == TW'(LOCK_TMO - 1)) begin
          state_nxt = IDLE;
          ptr_nxt   = inc_mod(owner);
          tmo_nxt   = '0;
        end else begin
          tmo_nxt = tmo + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state    <= IDLE;
      owner    <= '0;
      tmo      <= '0;
      rf_ld    <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      grant_id <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      tmo   <= tmo_nxt;
      rf_ld <= xfer;
      if (xfer) begin
        rf_addr  <= addr_sel;
        rf_data  <= data_sel;
        grant_id <= xidx;
      end
    end
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port among NREQ writeback requesters, for example ALU result, load data, and PC/link update. Each requester uses a valid/ready handshake. The block drives the register file's load-enable, 4-bit destination select and 32-bit write data from a registered output stage. It supports locked bursts so one requester (e.g. a multi-register load) can own the port for consecutive writes.

Parameters:
NREQ, 3, number of requesters
DW, 32, write data width
AW, 4, register address width (16 registers)
LOCK_TMO, 8, idle cycles after which a locked owner loses the port

Ports:
Clk  in  1  clock; all state updates on rising edge
Clr  in  1  reset, synchronous, active-high
req_valid  in  NREQ  requester i has a write pending
req_ready  out  NREQ  requester i's write is accepted this cycle
req_addr  in  NREQ*AW  destination register, slice i = [i*AW +: AW]
req_data  in  NREQ*DW  write data, slice i = [i*DW +: DW]
req_lock  in  NREQ  keep the port after this transfer
rf_ld  out  1  register file load enable
rf_addr  out  AW  register file destination select
rf_data  out  DW  register file write data
grant_id  out  clog2(NREQ)  index of the last accepted requester
busy  out  1  high while in LOCK

Behaviour:
- Clock and reset: one clock, Clk. Reset Clr is synchronous and active-high.
- Reset values (Clr=1 at an edge):
  - rf_ld=0, rf_addr=0, rf_data=0, grant_id=0, busy=0.
  - State=IDLE, round-robin pointer=0, timeout counter=0.
  - req_ready is all-zero while Clr=1.
- Transfer: requester i transfers when req_valid[i] & req_ready[i] are both high at a rising edge.
  - req_ready is combinational from state, pointer and req_valid.
  - At most one bit of req_ready is high per cycle; never assert ready to a non-valid requester.
- Latency:
  - Accepted at edge t: rf_ld=1, rf_addr, rf_data valid during cycle t..t+1.
  - The register file captures at edge t+1.
  - rf_ld is high for exactly one cycle per transfer; back-to-back transfers give rf_ld continuously high.
  - With no transfer, rf_ld=0; rf_addr and rf_data hold their last values.
- Ordering: writes reach rf_* in acceptance order. Same-address writes from different requesters resolve last-accepted-wins.
- FSM IDLE:
  - Grant the first valid requester scanning from pointer upward, modulo NREQ.
  - On transfer, pointer <= granted+1 mod NREQ.
  - If that transfer has req_lock=1, go to LOCK with owner=granted; busy=1 from the next cycle.
- FSM LOCK:
  - req_ready is high only for the owner, and only when the owner is valid. All others are stalled.
  - Owner transfer with req_lock=1: stay in LOCK, timeout counter <= 0.
  - Owner transfer with req_lock=0: go to IDLE; pointer <= owner+1.
  - Owner not valid: timeout counter increments. When it reaches LOCK_TMO-1 with the owner still not valid, go to IDLE and set pointer <= owner+1.
- Single requester: NREQ requests from one source with lock=0 are granted every cycle (100% throughput).
- Reset mid-operation: a transfer coincident with Clr=1 is dropped, not written; LOCK is abandoned.
- Width: grant_id width is clog2(NREQ), minimum 1. Address and data slices are passed through unmodified.

Optional Feature:
Macro RF_ARB_FIXED_PRIO_EN.
- Defined: IDLE arbitration is fixed priority, lowest index wins. The pointer register is not implemented; LOCK behaviour is unchanged.
- Undefined (default): round-robin as described above.

Decomposition:
- Package rf_ctrl_pkg holds:
  - Default constants RF_AW=4, RF_DW=32, RF_NREQ=3, RF_LOCK_TMO=8.
  - State typedef arb_state_t {IDLE, LOCK}.
- One sub-module, rf_rr_pick: combinational pick of the first set bit of req_valid at or after the pointer. It outputs a one-hot grant plus index. The fixed-priority variant is pointer tied to 0.

Test Plan:
- Reset: Clr=1 for 2 cycles with all req_valid=1 -> req_ready=000, rf_ld=0, rf_addr=0, rf_data=0; after release the first grant goes to requester 0.
- Round-robin: all three valid continuously with lock=0, addresses 1/2/3, data 0xA/0xB/0xC -> grants 0,1,2,0,…; rf_ld high every cycle; rf_addr sequence 1,2,3,1 one cycle after each accept.
- Locked burst: requester 1 writes regs 4,5,6 with lock=1,1,0 while 0 and 2 are valid -> ready only to 1 for 3 transfers; busy=1 for 2 cycles; next grant goes to 2.
- Lock timeout: requester 2 transfers with lock=1, then drops valid for 8 cycles while 0 is valid -> requester 0 gets ready on the cycle after the 8th idle cycle; busy falls together with that grant.
- Same-address race: requester 0 writes r8=0x10, requester 1 writes r8=0x20 in consecutive grants -> rf_data 0x10 then 0x20; register file r8 ends at 0x20.
- Reset mid-lock: Clr=1 asserted during an owner transfer -> no rf_ld the next cycle; state IDLE; pointer 0.
